regfile_mp_scoreboard: RTL

- Parametrised successor to the CPU's 16x32 three-read/one-write register file.
- Configurable data width, register count and read-port count.
- Two write ports with fixed priority.
- Per-register busy scoreboard, so the issue stage can detect outstanding writebacks without an external hazard table.
- Sits between decode/register-read and the writeback stages of the pipeline.

---
 rtl/regfile_mp_scoreboard_if.sv | 33 +++
 rtl/regfile_mp_scoreboard.sv | 123 ++++++++++++
 2 files changed

// File: rtl/regfile_mp_scoreboard_if.sv
// Bundles the register-read, writeback and claim buses of regfile_mp_scoreboard.
// The pipeline side uses the master modport and the register file uses the slave modport.
interface regfile_mp_scoreboard_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 16,
    parameter int NUM_READ_PORTS = 3,
    parameter int SEL_WIDTH      = $clog2(NUM_REGS)
);
    logic [NUM_READ_PORTS*SEL_WIDTH-1:0]  rd_sel;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data;
    logic [NUM_READ_PORTS-1:0]            rd_busy;
    logic                                 wr0_en;
    logic [SEL_WIDTH-1:0]                 wr0_sel;
    logic [DATA_WIDTH-1:0]                wr0_data;
    logic                                 wr1_en;
    logic [SEL_WIDTH-1:0]                 wr1_sel;
    logic [DATA_WIDTH-1:0]                wr1_data;
    logic                                 claim_en;
    logic [SEL_WIDTH-1:0]                 claim_sel;
    logic [NUM_REGS-1:0]                  busy_vec;

    modport master (
        output rd_sel, wr0_en, wr0_sel, wr0_data, wr1_en, wr1_sel, wr1_data,
               claim_en, claim_sel,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_sel, wr0_en, wr0_sel, wr0_data, wr1_en, wr1_sel, wr1_data,
               claim_en, claim_sel,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port register file with two prioritised write ports and a per-register
// busy scoreboard. Register 0 is hard-wired to zero and can never become busy.
// Reads are synchronous with one cycle of latency.
// Optional macro REGFILE_MP_SCOREBOARD_BYPASS_EN: when defined, read ports forward
// same-cycle write data and the post-edge busy state; when undefined, reads see
// the array and scoreboard as they stood before the edge.
module regfile_mp_scoreboard #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 16,
    parameter int NUM_READ_PORTS = 3,
    parameter int SEL_WIDTH      = $clog2(NUM_REGS)
) (
    input logic                    clk,
    input logic                    rst,
    regfile_mp_scoreboard_if.slave bus
);
    localparam logic [SEL_WIDTH:0] REG_LIMIT = (SEL_WIDTH+1)'(NUM_REGS);

    logic [DATA_WIDTH-1:0]                regs [NUM_REGS];
    logic [NUM_REGS-1:0]                  busy_q;
    logic [NUM_REGS-1:0]                  busy_d;
    logic [NUM_REGS-1:0]                  wr0_hit;
    logic [NUM_REGS-1:0]                  wr1_hit;
    logic [NUM_REGS-1:0]                  claim_hit;
    logic [SEL_WIDTH-1:0]                 rd_idx [NUM_READ_PORTS];
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data_q;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data_d;
    logic [NUM_READ_PORTS-1:0]            rd_busy_q;
    logic [NUM_READ_PORTS-1:0]            rd_busy_d;

    // A select is readable only when it names a real, non-zero register
    function automatic logic sel_ok(input logic [SEL_WIDTH-1:0] sel);
        return (sel != '0) && ({1'b0, sel} < REG_LIMIT);
    endfunction

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd_idx
        assign rd_idx[p] = bus.rd_sel[p*SEL_WIDTH +: SEL_WIDTH];
    end

    // Decode writes and claims into per-register hit vectors; register 0 never hits
    always_comb begin
        wr0_hit   = '0;
        wr1_hit   = '0;
        claim_hit = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            wr0_hit[r]   = bus.wr0_en   && (bus.wr0_sel   == SEL_WIDTH'(r));
            wr1_hit[r]   = bus.wr1_en   && (bus.wr1_sel   == SEL_WIDTH'(r));
            claim_hit[r] = bus.claim_en && (bus.claim_sel == SEL_WIDTH'(r));
        end
    end

    // Next scoreboard state: a claim beats a same-cycle write because the new producer is still outstanding
    always_comb begin
        busy_d = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (claim_hit[r]) begin
                busy_d[r] = 1'b1;
            end else if (wr0_hit[r] || wr1_hit[r]) begin
                busy_d[r] = 1'b0;
            end else begin
                busy_d[r] = busy_q[r];
            end
        end
    end

    // Read-port mux, with optional forwarding of this edge's writes and scoreboard update
    always_comb begin
        rd_data_d = '0;
        rd_busy_d = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            if (sel_ok(rd_idx[p])) begin
`ifdef REGFILE_MP_SCOREBOARD_BYPASS_EN
                if (wr1_hit[rd_idx[p]]) begin
                    rd_data_d[p*DATA_WIDTH +: DATA_WIDTH] = bus.wr1_data;
                end else if (wr0_hit[rd_idx[p]]) begin
                    rd_data_d[p*DATA_WIDTH +: DATA_WIDTH] = bus.wr0_data;
                end else begin
                    rd_data_d[p*DATA_WIDTH +: DATA_WIDTH] = regs[rd_idx[p]];
                end
                rd_busy_d[p] = busy_d[rd_idx[p]];
`else
                rd_data_d[p*DATA_WIDTH +: DATA_WIDTH] = regs[rd_idx[p]];
                rd_busy_d[p] = busy_q[rd_idx[p]];
`endif
            end
        end
    end

    // Register array update; load writeback (port 1) wins over ALU writeback on a collision
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            regs[0] <= '0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (wr1_hit[r]) begin
                    regs[r] <= bus.wr1_data;
                end else if (wr0_hit[r]) begin
                    regs[r] <= bus.wr0_data;
                end
            end
        end
    end

    // Scoreboard and registered read outputs; reset drops every pending claim
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_busy  = rd_busy_q;
    assign bus.busy_vec = busy_q;
endmodule
